xpe_out_wb: RTL and testbench

- Write-back receiver for the xpe post-processing output stream (256-bit data + valid, no backpressure).
- Buffers results in a small FIFO and generates addressed write requests to the output feature-map buffer.
- Address pattern is 2-D: base + row*stride + col.
- Sits between the xpe stage and the output buffer arbiter in npu_core; absorbs arbiter stalls so xpe never throttles.

---
 rtl/xpe_out_wb.sv | 209 ++++++++++++++++++++
 tb/tb_xpe_out_wb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xpe_out_wb.sv
`default_nettype none
// ============================================================================
// Module   : xpe_out_wb
// Brief    : xpe output write-back. FIFO-buffers result words and issues 2-D
//            addressed writes (base + row*stride + col) to the output buffer.
//            Optional stall/occupancy counters: define XPE_OUT_WB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xpe_out_wb #(
    parameter int ADDR_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH-1:0] i_row_stride,
    input  logic [7:0]            i_words_per_row,
    input  logic [7:0]            i_row_num,
    input  logic [DATA_WIDTH-1:0] i_xpe_dat,
    input  logic                  i_xpe_dat_vld,
    output logic                  o_wr_req,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    input  logic                  i_wr_ack,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_err
`ifdef XPE_OUT_WB_PERF_EN
    ,
    output logic [31:0]                   o_stall_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_max
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] row_addr_q, row_addr_d;
    logic [7:0]            wpr_q, wpr_d;
    logic [7:0]            rnum_q, rnum_d;
    logic [7:0]            col_q, col_d;
    logic [7:0]            row_q, row_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic w_req;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_last_col;
    logic w_last_row;

    assign w_req      = (state_q == ST_RUN) && (count_q != '0);
    assign w_pop      = w_req && i_wr_ack && !i_clr;
    assign w_full     = (count_q == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push     = (state_q == ST_RUN) && i_xpe_dat_vld && !i_clr && (!w_full || w_pop);
    assign w_last_col = (col_q == (wpr_q - 8'd1));
    assign w_last_row = (row_q == (rnum_q - 8'd1));

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        row_addr_d = row_addr_q;
        wpr_d      = wpr_q;
        rnum_d     = rnum_q;
        col_d      = col_q;
        row_d      = row_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_d      = err_q;

        if (i_clr) begin
            state_d  = ST_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 2'b00;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

            if (i_xpe_dat_vld) begin
                if (state_q != ST_RUN) err_d[1] = 1'b1;
                else if (!w_push)      err_d[0] = 1'b1;
            end

            if (w_pop) begin
                if (w_last_col) begin
                    col_d      = 8'd0;
                    row_d      = row_q + 8'd1;
                    row_addr_d = row_addr_q + stride_q;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        stride_d   = i_row_stride;
                        wpr_d      = i_words_per_row;
                        rnum_d     = i_row_num;
                        row_addr_d = i_base_addr;
                        col_d      = 8'd0;
                        row_d      = 8'd0;
                        state_d    = ((i_words_per_row == 8'd0) || (i_row_num == 8'd0))
                                     ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pop && w_last_col && w_last_row) state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            stride_q   <= '0;
            row_addr_q <= '0;
            wpr_q      <= '0;
            rnum_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            row_addr_q <= row_addr_d;
            wpr_q      <= wpr_d;
            rnum_q     <= rnum_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_q      <= err_d;
        end
    end

    // Storage carries no reset; occupancy tracking alone defines validity.
    always_ff @(posedge i_clk) begin
        if (w_push) mem_q[wr_ptr_q] <= i_xpe_dat;
    end

    assign o_wr_req  = w_req;
    assign o_wr_addr = row_addr_q + ADDR_WIDTH'(col_q);
    assign o_wr_data = w_req ? mem_q[rd_ptr_q] : '0;
    assign o_busy    = (state_q != ST_IDLE);
    assign o_done    = (state_q == ST_DONE);
    assign o_err     = err_q;

`ifdef XPE_OUT_WB_PERF_EN
    logic [31:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] fifo_max_q, fifo_max_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fifo_max_d  = fifo_max_q;
        if (i_clr || ((state_q == ST_IDLE) && i_start)) begin
            stall_cnt_d = '0;
            fifo_max_d  = '0;
        end else begin
            if (w_req && !i_wr_ack && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_d = stall_cnt_q + 32'd1;
            if (count_d > fifo_max_q)
                fifo_max_d = count_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stall_cnt_q <= '0;
            fifo_max_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fifo_max_q  <= fifo_max_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_fifo_max  = fifo_max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xpe_out_wb.sv
`default_nettype none
// Bench for xpe_out_wb: directed and random jobs checked every cycle against a
// queue-based model; a few literal address/data expectations pin the model.
module tb_xpe_out_wb;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int DW    = 256;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          clr    = 1'b0;
    logic          start  = 1'b0;
    logic [AW-1:0] base   = '0;
    logic [AW-1:0] stride = '0;
    logic [7:0]    wpr    = '0;
    logic [7:0]    rows   = '0;
    logic [DW-1:0] dat    = '0;
    logic          vld    = 1'b0;
    logic          ack    = 1'b0;

    logic          o_wr_req;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
    logic [1:0]    o_err;

    always #5 clk = ~clk;

    xpe_out_wb #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_clr          (clr),
        .i_start        (start),
        .i_base_addr    (base),
        .i_row_stride   (stride),
        .i_words_per_row(wpr),
        .i_row_num      (rows),
        .i_xpe_dat      (dat),
        .i_xpe_dat_vld  (vld),
        .o_wr_req       (o_wr_req),
        .o_wr_addr      (o_wr_addr),
        .o_wr_data      (o_wr_data),
        .i_wr_ack       (ack),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: job phase, word queue, sticky errors, words accepted.
    logic [DW-1:0] m_q[$];
    int            m_st = 0;            // 0 idle, 1 running, 2 done
    logic [1:0]    m_err = 2'b00;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_stride = '0;
    int            m_wpr = 1;
    int            m_rows = 1;
    int            m_k = 0;

    logic [AW-1:0] log_addr[$];
    logic [DW-1:0] log_data[$];

    function automatic logic [AW-1:0] m_addr();
        int unsigned a;
        a = int'(m_base) + (m_k / m_wpr) * int'(m_stride) + (m_k % m_wpr);
        return a[AW-1:0];
    endfunction

    task automatic model_step();
        bit req, pop, push;
        if (clr) begin
            m_q.delete();
            m_err = 2'b00;
            m_st  = 0;
            return;
        end
        req  = (m_st == 1) && (m_q.size() > 0);
        pop  = req && ack;
        push = 1'b0;
        if (vld) begin
            if (m_st != 1)                        m_err[1] = 1'b1;
            else if (m_q.size() < DEPTH || pop)   push = 1'b1;
            else                                  m_err[0] = 1'b1;
        end
        case (m_st)
            0: if (start) begin
                m_base = base; m_stride = stride;
                m_wpr = int'(wpr); m_rows = int'(rows); m_k = 0;
                m_st = (wpr == 0 || rows == 0) ? 2 : 1;
            end
            1: if (pop) begin
                void'(m_q.pop_front());
                m_k++;
                if (m_k == m_wpr * m_rows) m_st = 2;
            end
            default: m_st = 0;
        endcase
        if (push) m_q.push_back(dat);
    endtask

    always @(posedge clk) begin
        bit exp_req;
        if (rst_n && !clr && o_wr_req && ack) begin
            log_addr.push_back(o_wr_addr);
            log_data.push_back(o_wr_data);
        end
        if (!rst_n) begin
            m_q.delete(); m_st = 0; m_err = 2'b00; m_k = 0;
        end else begin
            model_step();
        end
        #1;
        exp_req = (m_st == 1) && (m_q.size() > 0);
        chk("wr_req", DW'(o_wr_req), DW'(exp_req));
        if (exp_req) begin
            chk("wr_addr", DW'(o_wr_addr), DW'(m_addr()));
            chk("wr_data", o_wr_data, m_q[0]);
        end
        chk("busy", DW'(o_busy), DW'(m_st != 0));
        chk("done", DW'(o_done), DW'(m_st == 2));
        chk("err",  DW'(o_err),  DW'(m_err));
        if (o_done) done_cnt++;
    end

    task automatic nc();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic wait_idle(input int bound, input bit must, input string name);
        int i = 0;
        while (m_st != 0 && i < bound) begin
            nc();
            i++;
        end
        if (must) begin
            n_tests++;
            if (m_st != 0) begin
                n_fail++;
                $display("FAIL %s: job still active after %0d cycles, required idle", name, bound);
            end
        end
    endtask

    task automatic begin_job(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [7:0] w, input logic [7:0] r);
        nc();
        start = 1'b1; base = b; stride = s; wpr = w; rows = r;
        nc();
        start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        nc();
        clr = 1'b0;
    endtask

    logic [AW-1:0] t1_exp [6] = '{16'h0100, 16'h0101, 16'h0102, 16'h0110, 16'h0111, 16'h0112};
    logic [AW-1:0] t4_exp [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [AW-1:0] t6_exp [4] = '{16'h0500, 16'h0501, 16'h0510, 16'h0511};
    logic [DW-1:0] sent[$];

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) nc();
        chk("rst_req",  DW'(o_wr_req),  '0);
        chk("rst_busy", DW'(o_busy),    '0);
        chk("rst_done", DW'(o_done),    '0);
        chk("rst_err",  DW'(o_err),     '0);
        chk("rst_addr", DW'(o_wr_addr), '0);
        chk("rst_data", o_wr_data,      '0);
        rst_n = 1'b1;
        nc();

        // 1: 3x2 job, ack always high
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack = 1'b1;
        begin_job(16'h0100, 16'h0010, 8'd3, 8'd2);
        for (int i = 0; i < 6; i++) begin
            vld = 1'b1; dat = rnd();
            nc();
        end
        vld = 1'b0;
        wait_idle(20, 1'b1, "t1_idle");
        nc();
        chk("t1_nwr", DW'(log_addr.size()), DW'(6));
        for (int i = 0; i < 6; i++) chk("t1_addr", DW'(log_addr[i]), DW'(t1_exp[i]));
        chk("t1_done_cnt", DW'(done_cnt), DW'(1));
        chk("t1_err", DW'(o_err), '0);

        // 2: overflow with ack held low, then drain
        log_addr.delete(); log_data.delete(); sent.delete(); ack = 1'b0;
        begin_job(16'h2000, 16'h0040, 8'd4, 8'd4);
        for (int i = 0; i < 8; i++) begin
            vld = 1'b1; dat = rnd(); sent.push_back(dat);
            nc();
        end
        vld = 1'b0;
        chk("t2_req_full", DW'(o_wr_req), DW'(1));
        chk("t2_err_full", DW'(o_err), '0);
        vld = 1'b1; dat = rnd();
        nc();
        vld = 1'b0;
        chk("t2_ovf", DW'(o_err), DW'(2'b01));
        ack = 1'b1;
        repeat (10) nc();
        chk("t2_nwr", DW'(log_data.size()), DW'(8));
        for (int i = 0; i < 8; i++) chk("t2_data", log_data[i], sent[i]);
        pulse_clr();

        // 3: full FIFO, push and pop in the same cycle
        log_addr.delete(); log_data.delete(); sent.delete(); ack = 1'b0;
        begin_job(16'h0400, 16'h0020, 8'd5, 8'd2);
        for (int i = 0; i < 8; i++) begin
            vld = 1'b1; dat = rnd(); sent.push_back(dat);
            nc();
        end
        ack = 1'b1; vld = 1'b1; dat = rnd(); sent.push_back(dat);
        nc();
        chk("t3_no_ovf", DW'(o_err), '0);
        dat = rnd(); sent.push_back(dat);
        nc();
        vld = 1'b0;
        wait_idle(30, 1'b1, "t3_idle");
        chk("t3_nwr", DW'(log_data.size()), DW'(10));
        for (int i = 0; i < 10; i++) chk("t3_data", log_data[i], sent[i]);

        // 4: address wrap
        log_addr.delete(); log_data.delete(); ack = 1'b1;
        begin_job(16'hFFFE, 16'h1234, 8'd4, 8'd1);
        for (int i = 0; i < 4; i++) begin
            vld = 1'b1; dat = rnd();
            nc();
        end
        vld = 1'b0;
        wait_idle(20, 1'b1, "t4_idle");
        chk("t4_nwr", DW'(log_addr.size()), DW'(4));
        for (int i = 0; i < 4; i++) chk("t4_addr", DW'(log_addr[i]), DW'(t4_exp[i]));
        chk("t4_err", DW'(o_err), '0);

        // 5: empty job, then valid while idle
        log_addr.delete(); log_data.delete();
        begin_job(16'h0700, 16'h0010, 8'd0, 8'd3);
        chk("t5_busy1", DW'(o_busy), DW'(1));
        chk("t5_done1", DW'(o_done), DW'(1));
        nc();
        chk("t5_busy2", DW'(o_busy), '0);
        chk("t5_done2", DW'(o_done), '0);
        vld = 1'b1; dat = rnd();
        nc();
        vld = 1'b0;
        chk("t5_err_idle", DW'(o_err), DW'(2'b10));
        chk("t5_nwr", DW'(log_addr.size()), '0);
        pulse_clr();
        chk("t5_err_clr", DW'(o_err), '0);

        // 6: clear mid-job, then a fresh job
        log_addr.delete(); log_data.delete(); ack = 1'b0;
        begin_job(16'h0300, 16'h0010, 8'd3, 8'd2);
        for (int i = 0; i < 5; i++) begin
            vld = 1'b1; dat = rnd();
            nc();
        end
        vld = 1'b0; ack = 1'b1;
        nc(); nc();
        ack = 1'b0;
        chk("t6_nwr_pre", DW'(log_addr.size()), DW'(2));
        pulse_clr();
        chk("t6_req", DW'(o_wr_req), '0);
        chk("t6_busy", DW'(o_busy), '0);
        chk("t6_err", DW'(o_err), '0);
        log_addr.delete(); log_data.delete(); ack = 1'b1;
        begin_job(16'h0500, 16'h0010, 8'd2, 8'd2);
        for (int i = 0; i < 4; i++) begin
            vld = 1'b1; dat = rnd();
            nc();
        end
        vld = 1'b0;
        wait_idle(20, 1'b1, "t6_idle");
        chk("t6_nwr", DW'(log_addr.size()), DW'(4));
        for (int i = 0; i < 4; i++) chk("t6_addr", DW'(log_addr[i]), DW'(t6_exp[i]));

        // Random jobs: gappy valids, random ack, config churn and stray starts
        for (int j = 0; j < 20; j++) begin
            int w, r, total, nsent, guard;
            w = int'($urandom_range(1, 5));
            r = int'($urandom_range(1, 4));
            total = w * r; nsent = 0; guard = 0;
            begin_job(AW'($urandom()), AW'($urandom()), 8'(w), 8'(r));
            while (nsent < total && guard < 400) begin
                vld = ($urandom_range(0, 1) == 1);
                if (vld) begin
                    dat = rnd();
                    nsent++;
                end
                ack    = ($urandom_range(0, 3) != 0);
                start  = ($urandom_range(0, 15) == 0);
                base   = AW'($urandom());
                stride = AW'($urandom());
                wpr    = 8'($urandom());
                rows   = 8'($urandom());
                nc();
                guard++;
            end
            vld = 1'b0; start = 1'b0; ack = 1'b1;
            wait_idle(40, 1'b0, "rnd_idle");
            pulse_clr();
        end

        nc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
